// File: rtl/cla_modadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_modadd_pipe
// Brief    : 2-stage pipelined modular add/sub mod Q using grouped CLA carries.
// Revision : 1.0
// ============================================================================
module cla_modadd_pipe #(
  parameter int WIDTH = 14,
  parameter int Q     = 12289,
  parameter int GRP   = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int             c_NGRP  = (WIDTH + GRP - 1) / GRP;
  localparam logic [WIDTH:0] c_Q_EXT = (WIDTH+1)'(Q);
  localparam logic [WIDTH-1:0] c_Q_W = WIDTH'(Q);

  logic             r_s1_valid;
  logic [WIDTH:0]   r_s1_raw;
  logic             r_s1_sub;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_r;
  logic [TAG_W-1:0] r_s2_tag;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_gen;
  logic [WIDTH-1:0] w_prop;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH:0]   w_raw;
  logic [WIDTH-1:0] w_raw_mq;
  logic [WIDTH-1:0] w_raw_pq;
  logic [WIDTH-1:0] w_r;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
  assign w_b_eff = in_sub ? ~in_b : in_b;
  assign w_gen   = in_a & w_b_eff;
  assign w_prop  = in_a ^ w_b_eff;

  // Each carry inside a group is a sum-of-products of that group's gen/prop
  // and the group carry-in; groups chain their carry-outs in a ripple.
  always_comb begin : p_cla
    logic t_acc;
    logic t_pall;
    w_carry    = '0;
    w_carry[0] = in_sub;
    t_acc      = 1'b0;
    t_pall     = 1'b1;
    for (int g = 0; g < c_NGRP; g++) begin
      for (int k = 0; k < GRP; k++) begin
        if (g*GRP + k < WIDTH) begin
          t_acc  = 1'b0;
          t_pall = 1'b1;
          for (int j = GRP-1; j >= 0; j--) begin
            if (j <= k) begin
              t_acc  = t_acc | (w_gen[g*GRP + j] & t_pall);
              t_pall = t_pall & w_prop[g*GRP + j];
            end
          end
          w_carry[g*GRP + k + 1] = t_acc | (t_pall & w_carry[g*GRP]);
        end
      end
    end
  end

  assign w_raw = {w_carry[WIDTH], w_prop ^ w_carry[WIDTH-1:0]};

  // raw[WIDTH] is the add carry or, for subtraction, the no-borrow flag (a >= b).
  assign w_raw_mq = r_s1_raw[WIDTH-1:0] - c_Q_W;
  assign w_raw_pq = r_s1_raw[WIDTH-1:0] + c_Q_W;

  always_comb begin
    w_r = r_s1_raw[WIDTH-1:0];
    if (r_s1_sub) begin
      if (!r_s1_raw[WIDTH]) w_r = w_raw_pq;
    end else begin
      if (r_s1_raw >= c_Q_EXT) w_r = w_raw_mq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_raw   <= '0;
      r_s1_sub   <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_raw <= w_raw;
        r_s1_sub <= in_sub;
        r_s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_r     <= '0;
      r_s2_tag   <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_r   <= w_r;
        r_s2_tag <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_r     = r_s2_r;
  assign out_tag   = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_cla_modadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_modadd_pipe
// Brief    : Self-checking bench for cla_modadd_pipe (vectors + random model).
// Revision : 1.0
// ============================================================================
module tb_cla_modadd_pipe;

  localparam int W  = 14;
  localparam int Q  = 12289;
  localparam int TW = 8;
  localparam int W2 = 23;
  localparam int Q2 = 8380417;
  localparam int W3 = 13;
  localparam int Q3 = 7681;

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_r;
  logic [TW-1:0] in_tag, out_tag;

  logic          v2, s2, rdy2, ov2;
  logic [W2-1:0] a2, b2, r2;
  logic [TW-1:0] t2, ot2;
  logic          v3, s3, rdy3, ov3;
  logic [W3-1:0] a3, b3, r3;
  logic [TW-1:0] t3, ot3;

  cla_modadd_pipe #(.WIDTH(W), .Q(Q), .GRP(4), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag));

  cla_modadd_pipe #(.WIDTH(W2), .Q(Q2), .GRP(4), .TAG_W(TW)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
    .in_a(a2), .in_b(b2), .in_sub(s2), .in_tag(t2),
    .out_valid(ov2), .out_ready(1'b1), .out_r(r2), .out_tag(ot2));

  cla_modadd_pipe #(.WIDTH(W3), .Q(Q3), .GRP(8), .TAG_W(TW)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3),
    .in_a(a3), .in_b(b3), .in_sub(s3), .in_tag(t3),
    .out_valid(ov3), .out_ready(1'b1), .out_r(r3), .out_tag(ot3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: add/sub then a single correction by Q, reduced mod 2**w.
  function automatic longint ref_op(input bit sub, input longint a, input longint b,
                                    input longint q, input int w);
    longint r;
    if (!sub) begin
      r = a + b;
      if (r >= q) r = r - q;
    end else begin
      r = a - b;
      if (r < 0) r = r + q;
    end
    return r & ((longint'(1) << w) - 1);
  endfunction

  typedef struct { longint r; longint tag; } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  bit            sb_on = 1'b0;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_r;
  logic [TW-1:0] prev_tag;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else if (sb_on) begin
      if (prev_stall) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_r", longint'(out_r), longint'(prev_r));
        chk("hold_tag", longint'(out_tag), longint'(prev_tag));
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = out_r;
      prev_tag   = out_tag;
      if (out_valid && out_ready) begin
        if (q1.size() == 0) chk("sb1_spurious", 1, 0);
        else begin
          e = q1.pop_front();
          chk("sb1_r", longint'(out_r), e.r);
          chk("sb1_tag", longint'(out_tag), e.tag);
        end
      end
      if (in_valid && in_ready)
        q1.push_back('{ref_op(in_sub, longint'(in_a), longint'(in_b), Q, W), longint'(in_tag)});
      if (ov2) begin
        if (q2.size() == 0) chk("sb2_spurious", 1, 0);
        else begin
          e = q2.pop_front();
          chk("sb2_r", longint'(r2), e.r);
          chk("sb2_tag", longint'(ot2), e.tag);
        end
      end
      if (v2) begin
        chk("sb2_ready", longint'(rdy2), 1);
        q2.push_back('{ref_op(s2, longint'(a2), longint'(b2), Q2, W2), longint'(t2)});
      end
      if (ov3) begin
        if (q3.size() == 0) chk("sb3_spurious", 1, 0);
        else begin
          e = q3.pop_front();
          chk("sb3_r", longint'(r3), e.r);
          chk("sb3_tag", longint'(ot3), e.tag);
        end
      end
      if (v3) begin
        chk("sb3_ready", longint'(rdy3), 1);
        q3.push_back('{ref_op(s3, longint'(a3), longint'(b3), Q3, W3), longint'(t3)});
      end
    end
  end

  typedef struct { bit sub; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] r; } vec_t;
  vec_t vt[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input logic [TW-1:0] tag);
    in_a   = W'($urandom_range(0, Q-1));
    in_b   = W'($urandom_range(0, Q-1));
    in_sub = 1'($urandom_range(0, 1));
    in_tag = tag;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat;
    int acc;
    int cnt;

    vt[0] = '{1'b0, W'(12288), W'(1),     W'(0)};
    vt[1] = '{1'b0, W'(6000),  W'(7000),  W'(711)};
    vt[2] = '{1'b0, W'(0),     W'(0),     W'(0)};
    vt[3] = '{1'b1, W'(5),     W'(7),     W'(12287)};
    vt[4] = '{1'b1, W'(100),   W'(100),   W'(0)};
    vt[5] = '{1'b1, W'(12288), W'(0),     W'(12288)};
    vt[6] = '{1'b0, W'(12288), W'(12288), W'(12287)};
    vt[7] = '{1'b1, W'(0),     W'(12288), W'(1)};
    vt[8] = '{1'b0, W'(16383), W'(16383), W'(4093)};

    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    v2 = 1'b0; s2 = 1'b0; a2 = '0; b2 = '0; t2 = '0;
    v3 = 1'b0; s3 = 1'b0; a3 = '0; b3 = '0; t3 = '0;
    repeat (3) tick();
    chk("rst_hold_out_valid", longint'(out_valid), 0);
    rst_n = 1'b1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_r", longint'(out_r), 0);
    chk("rst_out_tag", longint'(out_tag), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    sb_on = 1'b1;

    for (int i = 0; i < 9; i++) begin
      in_a = vt[i].a; in_b = vt[i].b; in_sub = vt[i].sub; in_tag = TW'(i);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        tick();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_r", i), longint'(out_r), longint'(vt[i].r));
      chk($sformatf("vec%0d_tag", i), longint'(out_tag), i);
      tick();
    end

    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        rand_op(TW'(k));
        in_valid = 1'b1;
        chk("b2b_in_ready", longint'(in_ready), 1);
      end else begin
        in_valid = 1'b0;
      end
      chk($sformatf("b2b_valid_c%0d", k), longint'(out_valid), (k >= 2 && k <= 9) ? 1 : 0);
      if (k >= 2 && k <= 9) chk("b2b_tag", longint'(out_tag), k - 2);
      tick();
    end

    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      rand_op(TW'(16 + k));
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    chk("stall_accepted", acc, 2);
    chk("stall_in_ready", longint'(in_ready), 0);
    chk("stall_out_valid", longint'(out_valid), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("stall_drained", q1.size(), 0);

    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_op(TW'(32 + k));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("midrst_pre_valid", longint'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_async_valid", longint'(out_valid), 0);
    q1.delete();
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) cnt++;
      tick();
    end
    chk("midrst_none_emitted", cnt, 0);

    for (int n = 0; n < 6000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_op(TW'(n));
      if ($urandom_range(0, 7) == 0) in_a = W'(Q - 1);
      if ($urandom_range(0, 7) == 0) in_b = W'(Q - 1);
      v2 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      a2 = W2'($urandom_range(0, Q2 - 1));
      b2 = W2'($urandom_range(0, Q2 - 1));
      t2 = TW'(n);
      v3 = 1'($urandom_range(0, 1));
      s3 = 1'($urandom_range(0, 1));
      a3 = W3'($urandom_range(0, Q3 - 1));
      b3 = W3'($urandom_range(0, Q3 - 1));
      t3 = TW'(n);
      tick();
    end
    in_valid = 1'b0; v2 = 1'b0; v3 = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("rand_drain_q1", q1.size(), 0);
    chk("rand_drain_q2", q2.size(), 0);
    chk("rand_drain_q3", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
